// File: rtl/boot_seq_pkg.sv
// Shared types for the boot clock sequencer: FSM state encoding, counter widths
// and the Moore output decode used by the top level.
package boot_seq_pkg;

  localparam int CNT_W   = 8;
  localparam int RETRY_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PLL_ON  = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_RUN     = 3'd4,
    ST_BACKOFF = 3'd5,
    ST_FAULT   = 3'd6,
    ST_BAD     = 3'd7
  } state_t;

  typedef struct packed {
    logic pll_en;
    logic switch_req;
    logic fabric_rst;
    logic done;
    logic fault;
  } outs_t;

  function automatic outs_t decode_outs(input state_t s);
    outs_t o;
    o = '{pll_en: 1'b0, switch_req: 1'b0, fabric_rst: 1'b1, done: 1'b0, fault: 1'b0};
    case (s)
      ST_PLL_ON: o.pll_en = 1'b1;
      ST_SWITCH: begin
        o.pll_en     = 1'b1;
        o.switch_req = 1'b1;
      end
      ST_RUN: begin
        o.pll_en     = 1'b1;
        o.switch_req = 1'b1;
        o.fabric_rst = 1'b0;
        o.done       = 1'b1;
      end
      ST_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/boot_seq_lock_filter.sv
// Two-flop synchroniser for the asynchronous PLL lock. With BOOT_SEQ_LOCK_FILTER_EN
// defined, lock asserts only after 4 consecutive high samples and drops on the first low.
module boot_seq_lock_filter (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  output logic lock
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], pll_lock};
  end

`ifdef BOOT_SEQ_LOCK_FILTER_EN
  // Counts consecutive high samples seen before the current one, saturating at 3.
  logic [1:0] run_q;

  always_ff @(posedge clk) begin
    if (reset || !sync_q[1])  run_q <= '0;
    else if (run_q != 2'd3)   run_q <= run_q + 2'd1;
  end

  assign lock = sync_q[1] && (run_q == 2'd3);
`else
  assign lock = sync_q[1];
`endif

endmodule

// File: rtl/boot_clk_sequencer.sv
// Boot clock sequencer: settle, enable PLL, wait for lock, switch the clock mux,
// release fabric reset; bounded retries then a sticky fault. Optional BOOT_SEQ_LOCK_FILTER_EN.
module boot_clk_sequencer
  import boot_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 64,
  parameter int MAX_RETRIES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pll_lock,
  input  logic               switch_ack,
  output logic               pll_en,
  output logic               switch_req,
  output logic               fabric_rst,
  output logic               done,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_req;
  logic               lock;
  outs_t              outs_q;

  boot_seq_lock_filter u_lock_filter (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .lock     (lock)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_req = 1'b0;
    case (state_q)
      ST_IDLE:              if (start) state_d = ST_SETTLE;
      ST_SETTLE, ST_BACKOFF: if (cnt_q >= SETTLE_LAST) state_d = ST_PLL_ON;
      ST_PLL_ON: begin
        if (lock)                       state_d   = ST_SWITCH;
        else if (cnt_q >= TIMEOUT_LAST) retry_req = 1'b1;
      end
      ST_SWITCH: begin
        // Losing lock outranks an ack arriving in the same cycle.
        if (!lock)                      retry_req = 1'b1;
        else if (switch_ack)            state_d   = ST_RUN;
        else if (cnt_q >= TIMEOUT_LAST) retry_req = 1'b1;
      end
      ST_RUN:   if (!lock) retry_req = 1'b1;
      ST_FAULT: ;
      default:  state_d = ST_IDLE;
    endcase

    if (retry_req) begin
      if (retry_q < RETRY_MAX) begin
        state_d = ST_BACKOFF;
        retry_d = retry_q + RETRY_W'(1);
      end else begin
        state_d = ST_FAULT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      outs_q  <= decode_outs(ST_IDLE);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      outs_q  <= decode_outs(state_d);
      // Counter restarts on each state entry and saturates rather than wrapping.
      if (state_d != state_q)      cnt_q <= '0;
      else if (cnt_q != '1)        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pll_en     = outs_q.pll_en;
  assign switch_req = outs_q.switch_req;
  assign fabric_rst = outs_q.fabric_rst;
  assign done       = outs_q.done;
  assign fault      = outs_q.fault;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: doc/boot_clk_sequencer.md
BOOT_CLK_SEQUENCER -- requirements
Module: boot_clk_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles to wait in SETTLE and BACKOFF (legal 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 64: maximum cycles to wait for PLL_LOCK or SWITCH_ACK (legal 1..255).
REQ-003 SHALL have parameter MAX_RETRIES, default 2: PLL restart attempts before FAULT (legal 0..3).
REQ-004 CLK  input  1  boot clock; all logic on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 START  input  1  begin sequence; sampled only in IDLE.
REQ-007 PLL_LOCK  input  1  PLL lock indicator; asynchronous to CLK, double-flop synchronised internally.
REQ-008 SWITCH_ACK  input  1  clock mux confirms the switch to the PLL clock.
REQ-009 PLL_EN  output  1  PLL enable.
REQ-010 SWITCH_REQ  output  1  request for the clock mux to select the PLL clock.
REQ-011 FABRIC_RST  output  1  active-high reset to user fabric.
REQ-012 DONE  output  1  sequence complete, PLL clock in use.
REQ-013 FAULT  output  1  sticky failure flag.
REQ-014 RETRY_CNT  output  2  retries consumed.
REQ-015 STATE  output  3  current FSM state encoding, for debug.

Function
REQ-016 All outputs SHALL be registered Moore outputs decoded from the state register; there is no combinational input-to-output path.
REQ-017 States and encodings: IDLE=0, SETTLE=1, PLL_ON=2, SWITCH=3, RUN=4, BACKOFF=5, FAULT=6; code 7 SHALL recover to IDLE.
REQ-018 IDLE: START=1 -> SETTLE; cycle counter cleared on every state entry.
REQ-019 SETTLE/BACKOFF: after exactly SETTLE_CYCLES cycles in state -> PLL_ON; PLL_EN=0.
REQ-020 PLL_ON: PLL_EN=1; synchronised lock=1 -> SWITCH; counter reaching LOCK_TIMEOUT first -> retry path (REQ-023).
REQ-021 SWITCH: PLL_EN=1, SWITCH_REQ=1; SWITCH_ACK=1 -> RUN; lock lost or LOCK_TIMEOUT reached -> retry path; lock loss SHALL take priority over ack in the same cycle.
REQ-022 RUN: PLL_EN=1, SWITCH_REQ=1, DONE=1, FABRIC_RST=0; lock lost -> retry path.
REQ-023 Retry path: if RETRY_CNT<MAX_RETRIES, go to BACKOFF and increment RETRY_CNT; otherwise go to FAULT.
REQ-024 FAULT: FAULT=1, PLL_EN=0, SWITCH_REQ=0, held until RESET; START is ignored.
REQ-025 FABRIC_RST SHALL be 1 in every state except RUN; DONE SHALL be 1 only in RUN.
REQ-026 The counter SHALL be 8 bits, saturating, and never wrap.

Reset
REQ-027 RESET=1 at a clock edge -> IDLE; PLL_EN=0, SWITCH_REQ=0, FABRIC_RST=1, DONE=0, FAULT=0, RETRY_CNT=0, STATE=0; this applies from any state, including mid-sequence.
REQ-028 RESET SHALL override START and PLL_LOCK in the same cycle.

Configuration
REQ-029 With BOOT_SEQ_LOCK_FILTER_EN defined, lock SHALL be considered asserted only after 4 consecutive synchronised-high samples, and deasserted on the first low sample; without the macro, the synchronised lock is used directly.

Structure
REQ-030 Package boot_seq_pkg SHALL hold the state enum, the counter width (8) and the RETRY_CNT width (2).
REQ-031 The synchroniser and the optional filter SHALL live in sub-module boot_seq_lock_filter.

Verification
REQ-032 Defaults, no filter: START pulse sampled at edge k -> STATE=1 at k+1; PLL_EN=1 at k+17.
REQ-033 PLL_LOCK tied high, SWITCH_ACK returned 3 cycles after SWITCH_REQ -> RUN reached, DONE=1, FABRIC_RST=0, RETRY_CNT=0.
REQ-034 PLL_LOCK held low -> three timeouts, RETRY_CNT 1 then 2, then FAULT=1, PLL_EN=0; a later START has no effect.
REQ-035 Lock dropped for 1 cycle (after sync) in RUN -> DONE=0, FABRIC_RST=1, BACKOFF, RETRY_CNT=1, RUN re-entered after relock.
REQ-036 RESET asserted in PLL_ON -> all outputs at reset values on the next edge; START then restarts the sequence.
REQ-037 With BOOT_SEQ_LOCK_FILTER_EN: a 3-cycle lock pulse -> remains in PLL_ON; a 4-cycle lock pulse -> SWITCH.
